// File: rtl/lvds_rx_pkg.sv
// Shared definitions for the LVDS receiver frame aligner: FSM state encoding and the default 6x frame pattern.
package lvds_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      SLIP   = 3'd2,
      WAIT   = 3'd3,
      LOCKED = 3'd4,
      FAIL   = 3'd5
   } state_e;

   localparam logic [5:0] FCLK_PATTERN_6X = 6'b111000;

endpackage

// File: rtl/lvds_rx_word_mon.sv
// Frame-lane word monitor: pattern compare plus the consecutive match (hunting) and mismatch (locked) run counters.
module lvds_rx_word_mon
   import lvds_rx_pkg::*;
#(
   parameter int               DESER        = 6,
   parameter logic [DESER-1:0] FCLK_PATTERN = FCLK_PATTERN_6X,
   parameter int               LOCK_CNT     = 16,
   parameter int               ERR_THRESH   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DESER-1:0] fclk,
   input  logic             hunt_en,
   input  logic             mon_en,
   output logic             match,
   output logic             lock_hit,
   output logic             err_hit
);

   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int EW = $clog2(ERR_THRESH + 1);

   logic [MW-1:0] match_cnt;
   logic [EW-1:0] err_cnt;

   assign match = (fclk == FCLK_PATTERN);

   // A mismatch on the word that would complete the run never produces a hit.
   assign lock_hit = hunt_en && match && (match_cnt == MW'(LOCK_CNT - 1));
   assign err_hit  = mon_en && !match && (err_cnt == EW'(ERR_THRESH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         match_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         match_cnt <= (hunt_en && match && !lock_hit) ? match_cnt + MW'(1) : '0;
         err_cnt   <= (mon_en && !match && !err_hit) ? err_cnt + EW'(1) : '0;
      end
   end

endmodule

// File: rtl/lvds_rx_frame_aligner.sv
// Frame-alignment controller for one ALTLVDS receiver: bit-slips until the frame lane matches, then monitors lock.
// Define LVDS_RX_OUT_REG_EN to add a second output register on sample_data/sample_valid (latency 2 instead of 1).
module lvds_rx_frame_aligner
   import lvds_rx_pkg::*;
#(
   parameter int               NR_CHAN      = 8,
   parameter int               DESER        = 6,
   parameter logic [DESER-1:0] FCLK_PATTERN = FCLK_PATTERN_6X,
   parameter int               LOCK_CNT     = 16,
   parameter int               SLIP_PULSE   = 2,
   parameter int               SLIP_WAIT    = 4,
   parameter int               ERR_THRESH   = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           rx_locked,
   input  logic [(NR_CHAN+1)*DESER-1:0]   rx_data,
   output logic                           rx_data_align,
   output logic [NR_CHAN*DESER-1:0]       sample_data,
   output logic                           sample_valid,
   output logic                           aligned,
   output logic                           align_err,
   output logic [$clog2(DESER+1)-1:0]     slip_cnt,
   output logic [7:0]                     realign_cnt
);

   localparam int LANE_W  = NR_CHAN * DESER;
   localparam int SLIP_W  = $clog2(DESER + 1);
   localparam int TMR_MAX = (SLIP_PULSE > SLIP_WAIT) ? SLIP_PULSE : SLIP_WAIT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_e            state_q, state_d;
   logic [TMR_W-1:0]  tmr_q;
   logic [SLIP_W-1:0] slip_q;
   logic              err_q;
   logic [7:0]        realign_q;
   logic [DESER-1:0]  fclk;
   logic              match, lock_hit, err_hit;

   assign fclk = rx_data[LANE_W +: DESER];

   lvds_rx_word_mon #(
      .DESER        (DESER),
      .FCLK_PATTERN (FCLK_PATTERN),
      .LOCK_CNT     (LOCK_CNT),
      .ERR_THRESH   (ERR_THRESH)
   ) u_word_mon (
      .clk      (clk),
      .reset    (reset),
      .fclk     (fclk),
      .hunt_en  (state_q == CHECK),
      .mon_en   (state_q == LOCKED),
      .match    (match),
      .lock_hit (lock_hit),
      .err_hit  (err_hit)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!rx_locked) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:   state_d = CHECK;
            CHECK: begin
               if (lock_hit)   state_d = LOCKED;
               else if (!match) state_d = (slip_q == SLIP_W'(DESER)) ? FAIL : SLIP;
            end
            SLIP:   if (tmr_q == TMR_W'(SLIP_PULSE - 1)) state_d = WAIT;
            WAIT:   if (tmr_q == TMR_W'(SLIP_WAIT - 1))  state_d = CHECK;
            LOCKED: if (err_hit) state_d = CHECK;
            FAIL:   state_d = FAIL;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      rx_data_align = 1'b0;
      aligned       = 1'b0;
      case (state_q)
         SLIP:    rx_data_align = 1'b1;
         LOCKED:  aligned       = 1'b1;
         default: ;
      endcase
   end

   // Pulse/wait timer restarts on every state change; slip and realign bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         tmr_q     <= '0;
         slip_q    <= '0;
         err_q     <= 1'b0;
         realign_q <= '0;
      end else begin
         tmr_q <= ((state_d == state_q) && (state_q == SLIP || state_q == WAIT)) ? tmr_q + TMR_W'(1) : '0;
         if (state_q == IDLE)
            slip_q <= '0;
         else if (state_q == CHECK && state_d == SLIP)
            slip_q <= slip_q + SLIP_W'(1);
         else if (state_q == LOCKED && state_d == CHECK)
            slip_q <= '0;
         if (state_d == FAIL)
            err_q <= 1'b1;
         if (state_q == LOCKED && state_d == CHECK)
            realign_q <= sat_inc8(realign_q);
      end
   end

   assign align_err   = err_q;
   assign slip_cnt    = slip_q;
   assign realign_cnt = realign_q;

   // Stage p0: capture data lanes and lock status
   logic [LANE_W-1:0] data_p0;
   logic              vld_p0;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_p0 <= '0;
         vld_p0  <= 1'b0;
      end else begin
         data_p0 <= rx_data[LANE_W-1:0];
         vld_p0  <= (state_q == LOCKED);
      end
   end

`ifdef LVDS_RX_OUT_REG_EN
   // Stage p1: extra output register for downstream timing
   logic [LANE_W-1:0] data_p1;
   logic              vld_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_p1 <= '0;
         vld_p1  <= 1'b0;
      end else begin
         data_p1 <= data_p0;
         vld_p1  <= vld_p0;
      end
   end

   assign sample_data  = data_p1;
   assign sample_valid = vld_p1;
`else
   assign sample_data  = data_p0;
   assign sample_valid = vld_p0;
`endif

endmodule

// File: tb/tb_lvds_rx_frame_aligner.sv
// Self-checking bench for lvds_rx_frame_aligner: behavioural alignment model plus directed scenarios.
module tb_lvds_rx_frame_aligner;

   localparam int NR_CHAN    = 8;
   localparam int DESER      = 6;
   localparam int LOCK_CNT   = 16;
   localparam int SLIP_PULSE = 2;
   localparam int SLIP_WAIT  = 4;
   localparam int ERR_THRESH = 4;
   localparam logic [5:0] PAT = 6'b111000;
`ifdef LVDS_RX_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_locked = 1'b0;
   logic [53:0] rx_data = '0;
   logic        rx_data_align;
   logic [47:0] sample_data;
   logic        sample_valid;
   logic        aligned;
   logic        align_err;
   logic [2:0]  slip_cnt;
   logic [7:0]  realign_cnt;

   always #5 clk = ~clk;

   lvds_rx_frame_aligner #(
      .NR_CHAN      (NR_CHAN),
      .DESER        (DESER),
      .FCLK_PATTERN (PAT),
      .LOCK_CNT     (LOCK_CNT),
      .SLIP_PULSE   (SLIP_PULSE),
      .SLIP_WAIT    (SLIP_WAIT),
      .ERR_THRESH   (ERR_THRESH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_locked     (rx_locked),
      .rx_data       (rx_data),
      .rx_data_align (rx_data_align),
      .sample_data   (sample_data),
      .sample_valid  (sample_valid),
      .aligned       (aligned),
      .align_err     (align_err),
      .slip_cnt      (slip_cnt),
      .realign_cnt   (realign_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Stimulus: frame lane = PAT rotated left by 'phase'; each slip rotates it back by one bit.
   int          phase = 0;
   bit          force_en = 1'b0;
   logic [5:0]  force_word = '0;
   logic [47:0] lanes = '0;

   // Model: phase 0 idle, 1 hunting, 2 slip pulse, 3 post-slip wait, 4 locked, 5 failed.
   int          m_phase = 0, m_run = 0, m_left = 0, m_slips = 0, m_errrun = 0, m_realign = 0;
   bit          m_err = 1'b0;
   logic [47:0] e_d0 = '0, e_d1 = '0;
   bit          e_v0 = 1'b0, e_v1 = 1'b0;

   task automatic model_step();
      bit mt;
      bit was_locked;
      mt = (rx_data[53:48] == PAT);
      was_locked = (m_phase == 4);
      if (reset) begin
         m_phase = 0; m_run = 0; m_left = 0; m_slips = 0; m_errrun = 0; m_realign = 0; m_err = 1'b0;
         e_d0 = '0; e_d1 = '0; e_v0 = 1'b0; e_v1 = 1'b0;
      end else begin
         e_d1 = e_d0; e_v1 = e_v0;
         e_d0 = rx_data[47:0]; e_v0 = was_locked;
         if (m_phase == 0) m_slips = 0;
         if (!rx_locked) begin
            m_phase = 0;
         end else begin
            case (m_phase)
               0: begin m_phase = 1; m_run = 0; end
               1: begin
                  if (mt) begin
                     m_run++;
                     if (m_run == LOCK_CNT) begin m_phase = 4; m_errrun = 0; end
                  end else begin
                     m_run = 0;
                     if (m_slips == DESER) begin m_phase = 5; m_err = 1'b1; end
                     else begin m_slips++; m_phase = 2; m_left = SLIP_PULSE; end
                  end
               end
               2: begin m_left--; if (m_left == 0) begin m_phase = 3; m_left = SLIP_WAIT; end end
               3: begin m_left--; if (m_left == 0) begin m_phase = 1; m_run = 0; end end
               4: begin
                  m_errrun = mt ? 0 : m_errrun + 1;
                  if (m_errrun == ERR_THRESH) begin
                     m_phase = 1; m_run = 0; m_slips = 0;
                     if (m_realign < 255) m_realign++;
                  end
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic compare();
      logic [47:0] ed;
      bit          ev;
`ifdef LVDS_RX_OUT_REG_EN
      ed = e_d1; ev = e_v1;
`else
      ed = e_d0; ev = e_v0;
`endif
      chk("aligned",       64'(aligned),       64'(m_phase == 4));
      chk("rx_data_align", 64'(rx_data_align), 64'(m_phase == 2));
      chk("align_err",     64'(align_err),     64'(m_err));
      chk("slip_cnt",      64'(slip_cnt),      64'(m_slips));
      chk("realign_cnt",   64'(realign_cnt),   64'(m_realign));
      chk("sample_valid",  64'(sample_valid),  64'(ev));
      chk("sample_data",   64'(sample_data),   64'(ed));
   endtask

   // Slip-pulse shape tracking; also emulates the deserialiser's bit-slip.
   bit prev_al = 1'b0, seen_pulse = 1'b0, skip_len = 1'b0;
   int hi = 0, lo = 0, pulses = 0;

   task automatic track();
      if (rx_data_align) begin
         if (!prev_al) begin
            if (seen_pulse) chk("slip_gap_min", 64'(lo >= SLIP_WAIT), 64'(1));
            seen_pulse = 1'b1;
            pulses++;
            hi = 0;
            phase = (phase + DESER - 1) % DESER;
         end
         hi++;
      end else begin
         if (prev_al) begin
            if (skip_len) skip_len = 1'b0;
            else chk("slip_pulse_len", 64'(hi), 64'(SLIP_PULSE));
            lo = 0;
         end
         lo++;
      end
      prev_al = rx_data_align;
   endtask

   task automatic tick();
      logic [11:0] dbl;
      logic [5:0]  fw;
      dbl = {PAT, PAT};
      fw = force_en ? force_word : 6'(dbl >> (6 - phase));
      rx_data = {fw, lanes};
      @(posedge clk);
      model_step();
      lanes = lanes + 48'h0101_0101_0103;
      #1;
      compare();
      track();
   endtask

   function automatic bit sel(input int which);
      case (which)
         0:       return aligned;
         1:       return align_err;
         default: return rx_data_align;
      endcase
   endfunction

   task automatic wait_sig(input int which, input int bound, input string name, output int n);
      n = 0;
      while (n < bound && !sel(which)) begin
         tick();
         n++;
      end
      chk({name, "_reached"}, 64'(sel(which)), 64'(1));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      skip_len = rx_data_align;
      seen_pulse = 1'b0;
      repeat (2) tick();
      pulses = 0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rx_locked = 1'b1;
      phase = 0;
      repeat (3) tick();
      chk("rst_aligned",      64'(aligned),       64'(0));
      chk("rst_align_pulse",  64'(rx_data_align), 64'(0));
      chk("rst_sample_valid", 64'(sample_valid),  64'(0));
      chk("rst_sample_data",  64'(sample_data),   64'(0));
      chk("rst_realign",      64'(realign_cnt),   64'(0));

      // Already aligned: lock after LOCK_CNT+1 edges, no slipping
      reset = 1'b0;
      wait_sig(0, 300, "t1_lock", n);
      chk("t1_lock_cycles", 64'(n), 64'(17));
      chk("t1_pulses", 64'(pulses), 64'(0));
      chk("t1_slip_cnt", 64'(slip_cnt), 64'(0));
      chk("t1_valid_lag", 64'(sample_valid), 64'(0));
      repeat (LAT) tick();
      chk("t1_valid_after", 64'(sample_valid), 64'(1));

      // Data path latency pin
      lanes = 48'h1234_5678_9ABC;
      repeat (LAT) tick();
      chk("t6_data_pin", 64'(sample_data), 64'h1234_5678_9ABC);
      repeat (5) tick();

      // Mismatch runs while locked
      force_en = 1'b1; force_word = 6'b000111;
      repeat (3) tick();
      force_en = 1'b0;
      tick();
      chk("t4_hold_lock", 64'(aligned), 64'(1));
      force_en = 1'b1;
      repeat (4) tick();
      force_en = 1'b0;
      chk("t4_unlocked", 64'(aligned), 64'(0));
      chk("t4_realign_cnt", 64'(realign_cnt), 64'(1));
      wait_sig(0, 300, "t4_relock", n);
      chk("t4_relock_cycles", 64'(n), 64'(16));

      // Frame lane rotated by 2
      do_reset();
      phase = 2;
      reset = 1'b0;
      wait_sig(0, 300, "t2_lock", n);
      chk("t2_pulses", 64'(pulses), 64'(2));
      chk("t2_slip_cnt", 64'(slip_cnt), 64'(2));
      repeat (3) tick();

      // Never-matching frame lane
      do_reset();
      force_en = 1'b1; force_word = 6'b101010;
      reset = 1'b0;
      wait_sig(1, 300, "t3_fail", n);
      chk("t3_pulses", 64'(pulses), 64'(6));
      chk("t3_slip_cnt", 64'(slip_cnt), 64'(6));
      chk("t3_aligned", 64'(aligned), 64'(0));
      repeat (40) tick();
      chk("t3_no_more_pulses", 64'(pulses), 64'(6));
      rx_locked = 1'b0;
      tick();
      chk("t3_err_held", 64'(align_err), 64'(1));
      rx_locked = 1'b1;
      force_en = 1'b0;
      repeat (2) tick();

      // rx_locked lost mid-slip
      do_reset();
      phase = 2;
      reset = 1'b0;
      wait_sig(2, 60, "t5_slip", n);
      rx_locked = 1'b0;
      skip_len = 1'b1;
      tick();
      chk("t5_align_drop", 64'(rx_data_align), 64'(0));
      chk("t5_slip_held", 64'(slip_cnt), 64'(1));
      tick();
      chk("t5_slip_clear", 64'(slip_cnt), 64'(0));
      rx_locked = 1'b1;
      seen_pulse = 1'b0;
      pulses = 0;
      wait_sig(0, 300, "t5_relock", n);
      chk("t5_pulses", 64'(pulses), 64'(1));
      chk("t5_slip_cnt", 64'(slip_cnt), 64'(1));

      // Reset mid-slip
      do_reset();
      phase = 3;
      reset = 1'b0;
      wait_sig(2, 60, "t7_slip", n);
      reset = 1'b1;
      skip_len = 1'b1;
      seen_pulse = 1'b0;
      tick();
      chk("t7_reset_drop", 64'(rx_data_align), 64'(0));
      reset = 1'b0;
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
